// File: rtl/vga_timing_decoder.sv
// vga_timing_decoder
//   Receive-side VGA timing recovery. Registers h_sync/v_sync/bright, detects
//   their edges, tracks active-pixel coordinates, emits line/frame strobes,
//   measures line period and lines per frame, and runs a lock FSM that
//   declares lock after LOCK_FRAMES consecutive good frames.
// Ports
//   clock        in   pixel clock, posedge
//   reset        in   asynchronous active-high reset
//   h_sync       in   horizontal sync, active low
//   v_sync       in   vertical sync, active low
//   bright       in   active-video window, active high
//   pix_x        out  column of current active pixel
//   pix_y        out  row of current active line
//   pix_valid    out  registered bright, aligned with pix_x/pix_y
//   line_start   out  1-cycle pulse on h_sync falling edge
//   frame_start  out  1-cycle pulse on v_sync falling edge
//   h_period     out  last measured line period (saturating)
//   v_lines      out  last measured lines per frame (saturating)
//   locked       out  timing matches H_TOTAL/V_TOTAL
//   timing_error out  1-cycle pulse on a mismatch while locked
module vga_timing_decoder #(
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_TOTAL     = 521,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       h_sync,
  input  logic       v_sync,
  input  logic       bright,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       pix_valid,
  output logic       line_start,
  output logic       frame_start,
  output logic [9:0] h_period,
  output logic [9:0] v_lines,
  output logic       locked,
  output logic       timing_error
);

  localparam logic [9:0] H_REF    = 10'(H_TOTAL);
  localparam logic [9:0] V_REF    = 10'(V_TOTAL);
  localparam logic [3:0] LOCK_REF = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t     state, state_next;
  logic [3:0] good_cnt, good_next;

  logic       s1_h, s1_v, s1_b;
  logic       s0_h, s0_v, s0_b;
  logic [9:0] hcnt;
  logic [9:0] lcnt;
  logic       have_ref;
  logic       frame_bad;

  logic       h_fall, v_fall, b_rise, b_fall;
  logic       h_bad, frame_good, h_stall, err;
  logic [3:0] good_inc;

  assign h_fall = s0_h & ~s1_h;
  assign v_fall = s0_v & ~s1_v;
  assign b_rise = s1_b & ~s0_b;
  assign b_fall = s0_b & ~s1_b;

  // A measurement is only judged once a previous h edge gave a reference.
  assign h_bad      = h_fall & have_ref & (hcnt != H_REF);
  assign frame_good = ~frame_bad & (lcnt == V_REF);
  assign h_stall    = (hcnt == '1);
  assign good_inc   = good_cnt + 4'd1;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= SEARCH;
      good_cnt <= '0;
    end else begin
      state    <= state_next;
      good_cnt <= good_next;
    end
  end

  always_comb begin
    state_next = state;
    good_next  = good_cnt;
    err        = 1'b0;
    case (state)
      SEARCH: begin
        if (v_fall) begin
          state_next = ACQUIRE;
          good_next  = '0;
        end
      end
      ACQUIRE: begin
        if (v_fall) begin
          if (frame_good) begin
            if (good_inc == LOCK_REF) begin
              state_next = LOCKED;
              good_next  = '0;
            end else begin
              good_next = good_inc;
            end
          end else begin
            good_next = '0;
          end
        end
      end
      LOCKED: begin
        if (h_bad || (v_fall && !frame_good) || h_stall) begin
          err        = 1'b1;
          state_next = SEARCH;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_h         <= 1'b1;
      s1_v         <= 1'b1;
      s1_b         <= 1'b0;
      s0_h         <= 1'b1;
      s0_v         <= 1'b1;
      s0_b         <= 1'b0;
      pix_x        <= '0;
      pix_y        <= '0;
      pix_valid    <= 1'b0;
      line_start   <= 1'b0;
      frame_start  <= 1'b0;
      h_period     <= '0;
      v_lines      <= '0;
      hcnt         <= '0;
      lcnt         <= '0;
      have_ref     <= 1'b0;
      frame_bad    <= 1'b0;
      locked       <= 1'b0;
      timing_error <= 1'b0;
    end else begin
      s1_h <= h_sync;
      s1_v <= v_sync;
      s1_b <= bright;
      s0_h <= s1_h;
      s0_v <= s1_v;
      s0_b <= s1_b;

      pix_valid   <= s1_b;
      line_start  <= h_fall;
      frame_start <= v_fall;

      if (b_rise)      pix_x <= '0;
      else if (s1_b)   pix_x <= pix_x + 10'd1;

      if (v_fall)      pix_y <= '0;
      else if (b_fall) pix_y <= pix_y + 10'd1;

      // Leaving LOCKED restarts the h counter so a persistent stall
      // cannot raise a second error.
      if (h_fall) begin
        h_period <= hcnt;
        hcnt     <= 10'd1;
      end else if (err) begin
        hcnt <= '0;
      end else if (!h_stall) begin
        hcnt <= hcnt + 10'd1;
      end

      if (err)         have_ref <= 1'b0;
      else if (h_fall) have_ref <= 1'b1;

      // An h edge coincident with v_sync fall belongs to the new frame.
      if (v_fall) begin
        v_lines   <= lcnt;
        lcnt      <= h_fall ? 10'd1 : 10'd0;
        frame_bad <= h_bad;
      end else begin
        if (h_fall && lcnt != '1) lcnt <= lcnt + 10'd1;
        if (h_bad)                frame_bad <= 1'b1;
      end

      locked       <= (state == LOCKED);
      timing_error <= err;
    end
  end

endmodule
